hs32_regfile: RTL and testbench

//  Parametrised multi-read-port register file; next generation of the core's dual-port regfile.

---
 rtl/hs32_regfile.sv | 125 ++++++++++++
 tb/tb_hs32_regfile.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/hs32_regfile.sv
// Multi-read-port register file with one write port, optional write-to-read bypass
// and a hardware sequencer that zeroes the array after reset or on request.
//
// state | meaning
// CLEAR | zeroing regs[ptr] one per cycle; ports ignored, busy=1
// RUN   | normal read/write operation, busy=0
module hs32_regfile #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 4,
    parameter int NRD     = 2,
    parameter int BYPASS  = 1,
    parameter int R0_ZERO = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    output logic                     busy,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wadr,
    input  logic [DATA_W-1:0]        din,
    input  logic [NRD-1:0]           re,
    input  logic [NRD*ADDR_W-1:0]    radr,
    output logic [NRD*DATA_W-1:0]    dout,
    output logic [NRD-1:0]           dvalid
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0]   regs_q [DEPTH];

    logic                wr_en;
    logic [ADDR_W-1:0]   wr_adr;
    logic [DATA_W-1:0]   wr_dat;
    logic                rd_en;
    logic [ADDR_W-1:0]   rd_adr [NRD];
    logic [DATA_W-1:0]   rd_sel [NRD];

    logic [NRD*DATA_W-1:0] dout_q;
    logic [NRD-1:0]        dvalid_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // The clear sequencer shares the single write port with normal writes.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wr_en   = 1'b0;
        wr_adr  = wadr;
        wr_dat  = din;
        rd_en   = 1'b0;
        case (state_q)
            CLEAR: begin
                wr_en  = 1'b1;
                wr_adr = ptr_q;
                wr_dat = '0;
                if (clr) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                    if (&ptr_q) state_d = RUN;
                end
            end
            RUN: begin
                if (clr) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end else begin
                    rd_en = 1'b1;
                    wr_en = we && !((R0_ZERO != 0) && (wadr == '0));
                end
            end
            default: begin
                state_d = CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    assign busy = (state_q == CLEAR);

    // Array has no reset; the clear sequencer provides the defined contents.
    always_ff @(posedge clk) begin
        if (wr_en) regs_q[wr_adr] <= wr_dat;
    end

    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rd_adr[i] = radr[i*ADDR_W +: ADDR_W];
            rd_sel[i] = regs_q[rd_adr[i]];
            if ((BYPASS != 0) && we && (wadr == rd_adr[i])) rd_sel[i] = din;
            if ((R0_ZERO != 0) && (rd_adr[i] == '0)) rd_sel[i] = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_q   <= '0;
            dvalid_q <= '0;
        end else begin
            for (int i = 0; i < NRD; i++) begin
                dvalid_q[i] <= rd_en && re[i];
                if (rd_en && re[i]) dout_q[i*DATA_W +: DATA_W] <= rd_sel[i];
            end
        end
    end

    assign dout   = dout_q;
    assign dvalid = dvalid_q;

endmodule

// File: tb/tb_hs32_regfile.sv
// Bench for hs32_regfile: two instances (bypass / r0-zero variants) share stimulus
// and are checked every cycle against a behavioural model, plus literal pins.
module tb_hs32_regfile;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic              clk   = 1'b0;
    logic              reset = 1'b1;
    logic              clr   = 1'b0;
    logic              we    = 1'b0;
    logic [AW-1:0]     wadr  = '0;
    logic [DW-1:0]     din   = '0;
    logic [2:0]        re    = '0;
    logic [3*AW-1:0]   radr  = '0;

    logic              busy_a, busy_b;
    logic [2*DW-1:0]   dout_a;
    logic [1:0]        dvalid_a;
    logic [3*DW-1:0]   dout_b;
    logic [2:0]        dvalid_b;

    int n_checks = 0;
    int n_fail   = 0;

    hs32_regfile #(.DATA_W(DW), .ADDR_W(AW), .NRD(2), .BYPASS(1), .R0_ZERO(0)) dut_a (
        .clk(clk), .reset(reset), .clr(clr), .busy(busy_a), .we(we), .wadr(wadr),
        .din(din), .re(re[1:0]), .radr(radr[2*AW-1:0]), .dout(dout_a), .dvalid(dvalid_a)
    );

    hs32_regfile #(.DATA_W(DW), .ADDR_W(AW), .NRD(3), .BYPASS(0), .R0_ZERO(1)) dut_b (
        .clk(clk), .reset(reset), .clr(clr), .busy(busy_b), .we(we), .wadr(wadr),
        .din(din), .re(re), .radr(radr), .dout(dout_b), .dvalid(dvalid_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_regs [2][DEPTH];
    logic [DW-1:0] m_dout [2][3];
    bit            m_dv   [2][3];
    int            m_left;
    bit            m_busy;

    function automatic bit bp(input int k);  return k == 0; endfunction
    function automatic bit r0z(input int k); return k == 1; endfunction
    function automatic int nrd(input int k); return (k == 0) ? 2 : 3; endfunction

    task automatic m_start_clear(input bit hard);
        m_left = DEPTH;
        m_busy = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < DEPTH; a++) m_regs[k][a] = '0;
            for (int i = 0; i < 3; i++) begin
                m_dv[k][i] = 1'b0;
                if (hard) m_dout[k][i] = '0;
            end
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_start_clear(1'b1);
        end else if (m_busy) begin
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < 3; i++) m_dv[k][i] = 1'b0;
            if (clr) m_left = DEPTH;
            else     m_left = m_left - 1;
            m_busy = (m_left > 0);
        end else if (clr) begin
            m_start_clear(1'b0);
        end else begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 3; i++) begin
                    logic [AW-1:0] a;
                    logic [DW-1:0] v;
                    m_dv[k][i] = 1'b0;
                    if (i < nrd(k) && re[i]) begin
                        a = radr[i*AW +: AW];
                        v = m_regs[k][a];
                        if (bp(k) && we && wadr == a) v = din;
                        if (r0z(k) && a == 0) v = '0;
                        m_dout[k][i] = v;
                        m_dv[k][i]   = 1'b1;
                    end
                end
                if (we && !(r0z(k) && wadr == 0)) m_regs[k][wadr] = din;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy_a", DW'(busy_a), DW'(m_busy));
        chk("busy_b", DW'(busy_b), DW'(m_busy));
        for (int i = 0; i < 2; i++) begin
            chk("dvalid_a", DW'(dvalid_a[i]), DW'(m_dv[0][i]));
            chk("dout_a", dout_a[i*DW +: DW], m_dout[0][i]);
        end
        for (int i = 0; i < 3; i++) begin
            chk("dvalid_b", DW'(dvalid_b[i]), DW'(m_dv[1][i]));
            chk("dout_b", dout_b[i*DW +: DW], m_dout[1][i]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        clr = 1'b0; we = 1'b0; re = '0;
    endtask

    task automatic count_busy(input string name);
        int bc;
        bc = 0;
        while (busy_a && bc < 40) begin
            tick();
            bc++;
        end
        chk(name, DW'(bc), DW'(16));
    endtask

    initial begin
        m_start_clear(1'b1);
        #1 reset = 1'b0;
        tick(); tick();
        reset = 1'b1;

        // T1: clear length and all-zero contents
        count_busy("t1_busy_len");
        for (int r = 0; r < DEPTH; r++) begin
            re = 3'b011;
            radr = {AW'(0), AW'(r), AW'(r)};
            tick();
            chk("t1_dout", dout_a[DW-1:0], '0);
            chk("t1_dvalid", DW'(dvalid_a), DW'(2'b11));
        end
        idle();

        // T2: write then read, then hold
        we = 1'b1; wadr = 4'd3; din = 32'hDEADBEEF;
        tick();
        we = 1'b0; re = 3'b001; radr = 12'h003;
        tick();
        chk("t2_dout", dout_a[DW-1:0], 32'hDEADBEEF);
        chk("t2_dvalid", DW'(dvalid_a[0]), DW'(1));
        re = '0;
        tick();
        chk("t2_dvalid_off", DW'(dvalid_a[0]), DW'(0));
        chk("t2_hold", dout_a[DW-1:0], 32'hDEADBEEF);

        // T3: same-cycle write/read, bypass vs none
        we = 1'b1; wadr = 4'd5; din = 32'h12345678; re = 3'b010; radr = 12'h050;
        tick();
        chk("t3_bypass", dout_a[2*DW-1:DW], 32'h12345678);
        chk("t3_nobypass", dout_b[2*DW-1:DW], '0);
        we = 1'b0;
        tick();
        chk("t3_reread", dout_b[2*DW-1:DW], 32'h12345678);

        // T4: r0 hardwired zero on instance b
        we = 1'b1; wadr = 4'd0; din = 32'hFFFFFFFF; re = 3'b011; radr = 12'h000;
        tick();
        chk("t4_same_clk_b", dout_b[DW-1:0], '0);
        chk("t4_same_clk_a", dout_a[DW-1:0], 32'hFFFFFFFF);
        we = 1'b0;
        tick();
        chk("t4_r0_p0", dout_b[DW-1:0], '0);
        chk("t4_r0_p1", dout_b[2*DW-1:DW], '0);
        chk("t4_a_r0", dout_a[DW-1:0], 32'hFFFFFFFF);

        // T5: clear request in RUN drops write and read
        clr = 1'b1; we = 1'b1; wadr = 4'd7; din = 32'h1; re = 3'b001; radr = 12'h003;
        tick();
        idle();
        chk("t5_dvalid", DW'(dvalid_a[0]), DW'(0));
        chk("t5_busy", DW'(busy_a), DW'(1));
        count_busy("t5_busy_len");
        re = 3'b011; radr = 12'h073;
        tick();
        chk("t5_r3", dout_a[DW-1:0], '0);
        chk("t5_r7", dout_a[2*DW-1:DW], '0);
        idle();

        // T6: reset in the middle of a clear
        we = 1'b1; wadr = 4'd9; din = 32'hA5A55A5A;
        tick();
        we = 1'b0; re = 3'b001; radr = 12'h009;
        tick();
        chk("t6_pre", dout_a[DW-1:0], 32'hA5A55A5A);
        idle();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (8) tick();
        reset = 1'b0;
        #1;
        chk("t6_dout_rst", dout_a[DW-1:0], '0);
        chk("t6_busy_rst", DW'(busy_a), DW'(1));
        tick();
        reset = 1'b1;
        count_busy("t6_busy_len");

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            clr  = ($urandom_range(0, 99) == 0);
            we   = $urandom_range(0, 1);
            wadr = AW'($urandom_range(0, DEPTH-1));
            din  = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 15)) : DW'($urandom);
            re   = 3'($urandom_range(0, 7));
            radr = 12'($urandom);
            if ($urandom_range(0, 3) == 0) radr[AW-1:0] = wadr;
            if ($urandom_range(0, 7) == 0) radr[2*AW-1:AW] = '0;
            if ($urandom_range(0, 599) == 0) begin
                reset = 1'b0;
                tick();
                reset = 1'b1;
            end
            tick();
        end
        idle();
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
